// File: rtl/hk628_audio_out.sv
// Audio output stage: boxcar-decimates the core's 50 MHz PCM to ~48 kHz, then applies a
// 5-bit volume with a soft-mute ramp and emits a registered sample with a one-cycle strobe.
module hk628_audio_out #(
    parameter int unsigned DIV   = 1042,
    parameter int unsigned SHIFT = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] pcm_in,
    input  logic        [4:0]  vol,
    input  logic               mute,
    output logic signed [15:0] pcm_out,
    output logic               sample_stb,
    output logic               ramp_busy
);

    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned AW  = 16 + SHIFT;
    localparam int unsigned WIN = 2 ** SHIFT;

    typedef enum logic [1:0] {StMuted, StRampUp, StActive, StRampDown} gain_st_e;

    logic        [CW-1:0] cnt_q, cnt_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [15:0]   avg_q, avg_d;
    logic        [4:0]    gain_q, gain_d;
    logic        [4:0]    target;
    logic                 s1_q;
    logic signed [19:0]   prod;
    logic signed [15:0]   pcm_d;
    logic                 last;
    gain_st_e             state_q, state_d;

    assign last   = (cnt_q == CW'(DIV - 1));
    assign target = mute ? 5'd0 : ((vol > 5'd16) ? 5'd16 : vol);

    // Sample counter and boxcar accumulator; inputs past the window are ignored.
    always_comb begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        acc_d = acc_q;
        if (cnt_q == '0) begin
            acc_d = {{SHIFT{pcm_in[15]}}, pcm_in};
        end else if (cnt_q < CW'(WIN)) begin
            acc_d = acc_q + {{SHIFT{pcm_in[15]}}, pcm_in};
        end
        avg_d = last ? 16'(acc_q >>> SHIFT) : avg_q;
    end

    // Gain FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StMuted;
            gain_q  <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
        end
    end

    // Gain FSM: next state, evaluated only at the stage-1 edge
    always_comb begin
        gain_d  = gain_q;
        state_d = state_q;
        if (last) begin
            if (gain_q < target) begin
                gain_d = gain_q + 5'd1;
            end else if (gain_q > target) begin
                gain_d = gain_q - 5'd1;
            end
            if (gain_d < target) begin
                state_d = StRampUp;
            end else if (gain_d > target) begin
                state_d = StRampDown;
            end else if (gain_d == 5'd0) begin
                state_d = StMuted;
            end else begin
                state_d = StActive;
            end
        end
    end

    // Gain FSM: outputs
    always_comb begin
        ramp_busy = 1'b0;
        unique case (state_q)
            StRampUp, StRampDown: ramp_busy = 1'b1;
            default:              ramp_busy = 1'b0;
        endcase
    end

    // 16 x 6-bit signed product; |avg * 16| <= 2^19 so 20 bits never overflow.
    assign prod  = 20'(avg_q) * 20'(signed'({1'b0, gain_q}));
    assign pcm_d = 16'(prod >>> 4);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            avg_q      <= '0;
            s1_q       <= 1'b0;
            pcm_out    <= '0;
            sample_stb <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            avg_q      <= avg_d;
            s1_q       <= last;
            sample_stb <= s1_q;
            if (s1_q) begin
                pcm_out <= pcm_d;
            end
        end
    end

endmodule

// File: tb/tb_hk628_audio_out.sv
// Scoreboard bench for hk628_audio_out at DIV=8, SHIFT=2: a cycle model pushes expected
// samples (value, busy flag, due cycle) at each window end; strobes pop and compare.
module tb_hk628_audio_out;

    localparam int DIV   = 8;
    localparam int SHIFT = 2;
    localparam int WIN   = 4;

    typedef struct {
        int due;
        int pcm;
        int busy;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [15:0] pcm_in = '0;
    logic        [4:0]  vol = '0;
    logic               mute = 1'b0;
    logic signed [15:0] pcm_out;
    logic               sample_stb;
    logic               ramp_busy;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    int   m_cnt = 0;
    int   m_acc = 0;
    int   m_gain = 0;
    int   last_pcm = 0;
    int   first_stb = -1;
    int   pcm_const = 0;
    bit   use_pat = 1'b0;

    hk628_audio_out #(.DIV(DIV), .SHIFT(SHIFT)) dut (
        .clk        (clk),
        .reset      (reset),
        .pcm_in     (pcm_in),
        .vol        (vol),
        .mute       (mute),
        .pcm_out    (pcm_out),
        .sample_stb (sample_stb),
        .ramp_busy  (ramp_busy)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // One cycle, entered and left at a negedge.
    task automatic step();
        exp_t e;
        int   p;
        int   tgt;
        int   avg;
        if (sample_stb) begin
            if (sb.size() == 0) begin
                check_eq("extra_stb", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("stb_cycle", cycle, e.due);
                check_eq("pcm_out", int'($signed(pcm_out)), e.pcm);
                check_eq("ramp_busy", int'(ramp_busy), e.busy);
                last_pcm = int'($signed(pcm_out));
                if (first_stb < 0) first_stb = cycle;
            end
        end else if (sb.size() != 0 && sb[0].due <= cycle) begin
            check_eq("missed_stb", 0, 1);
            void'(sb.pop_front());
        end

        if (use_pat) p = (m_cnt < WIN) ? 100 * (m_cnt + 1) : 9999;
        else if (m_cnt < WIN) p = pcm_const;
        else p = int'($signed(16'($urandom)));
        pcm_in = 16'(p);

        if (m_cnt == 0) m_acc = p;
        else if (m_cnt < WIN) m_acc += p;
        if (m_cnt == DIV - 1) begin
            tgt = mute ? 0 : ((vol > 16) ? 16 : int'(vol));
            if (m_gain < tgt) m_gain++;
            else if (m_gain > tgt) m_gain--;
            avg = m_acc >>> SHIFT;
            e.due  = cycle + 2;
            e.pcm  = (avg * m_gain) >>> 4;
            e.busy = (m_gain != tgt) ? 1 : 0;
            sb.push_back(e);
        end
        m_cnt = (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
        @(negedge clk);
        cycle++;
    endtask

    task automatic run_windows(input int n);
        repeat (n * DIV) step();
    endtask

    // Called at a negedge; returns at the negedge of cycle 0.
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        cycle = 0;
        m_cnt = 0;
        m_acc = 0;
        m_gain = 0;
        first_stb = -1;
        check_eq("rst_pcm", int'($signed(pcm_out)), 0);
        check_eq("rst_stb", int'(sample_stb), 0);
        check_eq("rst_busy", int'(ramp_busy), 0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Ramp up to full gain on a constant input.
        vol = 5'd16; pcm_const = 1000;
        run_windows(17);
        check_eq("first_stb", first_stb, 9);
        check_eq("ramp_final", last_pcm, 1000);
        check_eq("ramp_idle", int'(ramp_busy), 0);

        // Only the first 2^SHIFT inputs of a window count.
        use_pat = 1'b1;
        run_windows(2);
        check_eq("window_avg", last_pcm, 250);
        use_pat = 1'b0;

        pcm_const = -32768;
        run_windows(2);
        check_eq("neg_full", last_pcm, -32768);
        vol = 5'd1;
        run_windows(16);
        check_eq("neg_gain1", last_pcm, -2048);
        pcm_const = -1;
        run_windows(2);
        check_eq("m1_gain1", last_pcm, -1);
        pcm_const = 1;
        run_windows(2);
        check_eq("p1_gain1", last_pcm, 0);

        // Mute from gain 8, then release.
        do_reset();
        vol = 5'd16; pcm_const = 1000;
        run_windows(8);
        mute = 1'b1;
        run_windows(9);
        check_eq("mute_pcm", last_pcm, 0);
        check_eq("mute_idle", int'(ramp_busy), 0);
        mute = 1'b0;
        run_windows(2);
        check_eq("unmute_first", last_pcm, 62);
        check_eq("unmute_busy", int'(ramp_busy), 1);

        // Volume clamp.
        vol = 5'd31;
        run_windows(18);
        check_eq("clamp_pcm", last_pcm, 1000);
        check_eq("clamp_idle", int'(ramp_busy), 0);

        // Zero volume stays muted.
        do_reset();
        vol = 5'd0;
        run_windows(3);
        check_eq("vol0_pcm", last_pcm, 0);
        check_eq("vol0_busy", int'(ramp_busy), 0);

        // Reset in mid-window at full gain.
        vol = 5'd16; pcm_const = -500;
        run_windows(17);
        repeat (5) step();
        check_eq("pre_rst_cnt", m_cnt, 5);
        do_reset();
        run_windows(2);
        check_eq("post_rst_stb", first_stb, DIV + 1);
        run_windows(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/hk628_audio_out.md
# hk628_audio_out

Audio output stage downstream of `hk628_core`. It takes the core's free-running signed 16-bit PCM, sampled on every 50 MHz clock, and decimates it to a ~48 kHz sample stream using a boxcar average. It then applies a 5-bit volume with a click-free soft-mute ramp and presents a registered sample with a one-cycle strobe to the framework's AUDIO_L/AUDIO_R path.

## Interface
Parameters:
- `DIV`, default 1042: clock cycles per output sample (50 MHz / 1042 ≈ 47.985 kHz). Must be ≥ 2^SHIFT + 1.
- `SHIFT`, default 10: log2 of the number of input samples averaged per output sample.

Ports:
- `clk` in 1: single clock, 50 MHz in the system.
- `reset` in 1: synchronous, active-high.
- `pcm_in` in 16: signed PCM from `hk628_core.pcm_out`, valid every cycle.
- `vol` in 5: unsigned volume. Values 0..16 are the gain in 1/16 steps; values 17..31 clamp to 16.
- `mute` in 1: level; when high, the target gain is 0.
- `pcm_out` out 16: signed, registered output sample.
- `sample_stb` out 1: one-cycle pulse, high in the cycle `pcm_out` holds a new value.
- `ramp_busy` out 1: high while the current gain differs from the target gain.

## Operation
- Sample counter `cnt` counts 0..DIV-1 and wraps. Cycle 0 after reset deassertion has cnt=0.
- Accumulator is signed, 16+SHIFT bits.
  - At cnt=0: acc <= sext(pcm_in).
  - At 0<cnt<2^SHIFT: acc <= acc + sext(pcm_in).
  - For cnt ≥ 2^SHIFT: acc holds, and pcm_in is ignored.
  - No overflow is possible by width.
- Stage 1, at the edge ending a cnt=DIV-1 cycle:
  - avg_r <= acc >>> SHIFT (arithmetic, floor toward −∞, 16 bits).
  - gain_r steps one toward target: +1 if gain_r<target, −1 if gain_r>target, else hold.
- Target = mute ? 0 : min(vol,16). Both are sampled at the stage-1 edge only.
- Stage 2, at the next edge:
  - pcm_out <= (avg_r × gain_r) >>> 4. The product is signed 16×5→21 bits; the result always fits 16 bits, so there is no saturation.
  - sample_stb <= 1 for that one cycle.
- Gain FSM, state decoded from gain_r and target, transitions evaluated at stage 1:
  - MUTED (gain 0, target 0) → RAMP_UP when target>0.
  - RAMP_UP → ACTIVE when gain reaches target. A target decrease reverses it to RAMP_DOWN.
  - ACTIVE (gain=target≠0) → RAMP_UP or RAMP_DOWN on a target change.
  - RAMP_DOWN → MUTED when gain reaches 0, or → ACTIVE when gain reaches a nonzero target.
- ramp_busy = (gain_r ≠ current target). It is combinational from registers and the registered target.
- Retargeting mid-ramp is legal and takes effect at the next stage-1 edge. A full ramp from 0 to 16 takes 16 output samples.

## Timing
- Reset (synchronous): cnt=0, acc=0, avg_r=0, gain_r=0, registered target=0, pcm_out=0, sample_stb=0, ramp_busy=0. The FSM starts in MUTED.
- Reset asserted mid-operation clears everything on the next edge. Any in-flight window is discarded.
- sample_stb is high in cycles DIV+1, 2·DIV+1, … (cycle 0 is the first cycle after reset release). It is never high on consecutive cycles.
- Latency:
  - The last accumulated input (cnt=2^SHIFT−1) is visible at pcm_out DIV−2^SHIFT+2 cycles later.
  - A mute/vol change reaches the gain at the next stage-1 edge and is visible at pcm_out one cycle after that.
- pcm_out is stable between strobes.

## Test plan
Bench uses DIV=8, SHIFT=2.
- Ramp up: reset, then mute=0, vol=16, pcm_in=1000 constant.
  - Successive strobes give 62, 125, 187, …, 937, 1000.
  - ramp_busy falls after the 16th strobe.
  - The first strobe is in cycle 9.
- Averaging window: per window, pcm_in=100, 200, 300, 400 at cnt 0..3 and 9999 at cnt 4..7, gain at 16. pcm_out=250 (the tail is ignored).
- Sign and rounding: gain 16 with pcm_in=−32768 gives −32768. Gain 1 with −32768 gives −2048. Gain 1 with −1 gives −1. Gain 1 with +1 gives 0.
- Mute mid-ramp: at gain_r=8, assert mute.
  - Gain goes 7, 6, …, 0 over 8 strobes and pcm_out reaches 0.
  - ramp_busy then drops and the FSM is MUTED.
  - Deassert mute and the ramp resumes from 0.
- Clamp and zero: vol=31 ramps to gain 16 and holds. vol=0 with mute=0 keeps the FSM in MUTED, pcm_out=0 and ramp_busy=0.
- Reset mid-operation: assert reset for 1 cycle at gain 16, cnt=5.
  - The next cycle shows pcm_out=0, sample_stb=0 and ramp_busy=0.
  - The next strobe is exactly DIV+1 cycles after release.
